// File: rtl/itch_event_parser.sv
// ITCH 5.0 message parser: one message per AXI-Stream packet, decoded into a
// single event record (A/F/E/X/D) with valid/ready handoff and drop counters.
module itch_event_parser #(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_MSG_BYTES = 48,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic                      m_evt_valid,
  input  logic                      m_evt_ready,
  output logic [7:0]                m_evt_type,
  output logic [63:0]               m_evt_order_ref,
  output logic                      m_evt_side,
  output logic [31:0]               m_evt_shares,
  output logic [63:0]               m_evt_stock,
  output logic [31:0]               m_evt_price,
  output logic [47:0]               m_evt_timestamp,
  output logic [CNT_WIDTH-1:0]      msg_count,
  output logic [CNT_WIDTH-1:0]      err_count,
  output logic [CNT_WIDTH-1:0]      skip_count
);
  // state   | meaning
  // COLLECT | accepting beats into the byte buffer
  // CHECK   | one cycle: classify packet, drop or load the event record
  // EMIT    | event record presented until downstream takes it
  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = 16;

  typedef enum logic [1:0] {S_COLLECT, S_CHECK, S_EMIT} state_t;

  state_t            r_state, w_next;
  logic              r_ready_en;
  logic [BW-1:0]     r_byte_cnt;
  logic              r_ovf, r_bad_keep;
  logic [7:0]        r_buf [MAX_MSG_BYTES];
  logic              r_evt_valid;
  logic [7:0]        r_type;
  logic [63:0]       r_ref, r_stock;
  logic              r_side;
  logic [31:0]       r_shares, r_price;
  logic [47:0]       r_ts;
  logic [CNT_WIDTH-1:0] r_msg, r_err, r_skip;

  logic              w_tready, w_beat;
  logic [BW-1:0]     w_keep_cnt, w_req_len;
  logic [KW-1:0]     w_keep_p1;
  logic              w_keep_bad, w_ovf_beat, w_supported, w_is_af, w_good;
  logic [47:0]       w_ts;
  logic [63:0]       w_ref, w_stock;
  logic [31:0]       w_sh_af, w_sh_ex, w_price;

  assign w_beat    = s_axis_tvalid && w_tready;
  assign w_keep_p1 = s_axis_tkeep + {{(KW-1){1'b0}}, 1'b1};
  // A last beat must be a nonzero run of ones starting at lane 0.
  assign w_keep_bad = s_axis_tlast ? ((s_axis_tkeep == '0) || ((s_axis_tkeep & w_keep_p1) != '0))
                                   : (s_axis_tkeep != '1);

  always_comb begin
    w_keep_cnt = '0;
    w_ovf_beat = 1'b0;
    for (int k = 0; k < KW; k++) begin
      w_keep_cnt = w_keep_cnt + BW'(s_axis_tkeep[k]);
      if (s_axis_tkeep[k] && (r_byte_cnt + BW'(k) >= BW'(MAX_MSG_BYTES)))
        w_ovf_beat = 1'b1;
    end
  end

  always_comb begin
    w_supported = 1'b1;
    w_is_af     = 1'b0;
    w_req_len   = '0;
    case (r_buf[0])
      8'h41:   begin w_req_len = BW'(36); w_is_af = 1'b1; end
      8'h46:   begin w_req_len = BW'(40); w_is_af = 1'b1; end
      8'h45:   w_req_len = BW'(31);
      8'h58:   w_req_len = BW'(23);
      8'h44:   w_req_len = BW'(19);
      default: w_supported = 1'b0;
    endcase
  end

  assign w_good = w_supported && !r_ovf && !r_bad_keep && (r_byte_cnt == w_req_len);

  // Big-endian field assembly straight from the capture buffer.
  always_comb begin
    w_ts = '0; w_ref = '0; w_sh_af = '0; w_sh_ex = '0; w_stock = '0; w_price = '0;
    for (int i = 5;  i <= 10; i++) w_ts    = {w_ts[39:0],    r_buf[i]};
    for (int i = 11; i <= 18; i++) w_ref   = {w_ref[55:0],   r_buf[i]};
    for (int i = 19; i <= 22; i++) w_sh_ex = {w_sh_ex[23:0], r_buf[i]};
    for (int i = 20; i <= 23; i++) w_sh_af = {w_sh_af[23:0], r_buf[i]};
    for (int i = 24; i <= 31; i++) w_stock = {w_stock[55:0], r_buf[i]};
    for (int i = 32; i <= 35; i++) w_price = {w_price[23:0], r_buf[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (w_beat && s_axis_tlast) w_next = S_CHECK;
      S_CHECK:   w_next = w_good ? S_EMIT : S_COLLECT;
      S_EMIT:    if (r_evt_valid && m_evt_ready) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  always_comb begin
    w_tready = 1'b0;
    if (r_state == S_COLLECT) w_tready = r_ready_en;
  end

  // Capture buffer carries no reset; it is only read after a full packet lands.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int i = 0; i < MAX_MSG_BYTES; i++)
        for (int k = 0; k < KW; k++)
          if (s_axis_tkeep[k] && (r_byte_cnt + BW'(k) == BW'(i)))
            r_buf[i] <= s_axis_tdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_byte_cnt <= '0;
      r_ovf      <= 1'b0;
      r_bad_keep <= 1'b0;
      r_evt_valid <= 1'b0;
      r_type <= '0; r_ref <= '0; r_side <= 1'b0; r_shares <= '0;
      r_stock <= '0; r_price <= '0; r_ts <= '0;
      r_msg <= '0; r_err <= '0; r_skip <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        S_COLLECT: if (w_beat) begin
          r_byte_cnt <= r_byte_cnt + w_keep_cnt;
          if (w_ovf_beat) r_ovf <= 1'b1;
          if (w_keep_bad) r_bad_keep <= 1'b1;
        end
        S_CHECK: begin
          r_byte_cnt <= '0;
          r_ovf      <= 1'b0;
          r_bad_keep <= 1'b0;
          if (!w_supported) begin
            if (r_skip != '1) r_skip <= r_skip + 1'b1;
          end else if (!w_good) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
          end else begin
            r_evt_valid <= 1'b1;
            r_type   <= r_buf[0];
            r_ref    <= w_ref;
            r_ts     <= w_ts;
            r_side   <= w_is_af && (r_buf[19] == 8'h53);
            r_shares <= w_is_af ? w_sh_af : ((r_buf[0] == 8'h44) ? 32'h0 : w_sh_ex);
            r_stock  <= w_is_af ? w_stock : 64'h0;
            r_price  <= w_is_af ? w_price : 32'h0;
          end
        end
        S_EMIT: if (r_evt_valid && m_evt_ready) begin
          r_evt_valid <= 1'b0;
          r_msg       <= r_msg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready   = w_tready;
  assign m_evt_valid     = r_evt_valid;
  assign m_evt_type      = r_type;
  assign m_evt_order_ref = r_ref;
  assign m_evt_side      = r_side;
  assign m_evt_shares    = r_shares;
  assign m_evt_stock     = r_stock;
  assign m_evt_price     = r_price;
  assign m_evt_timestamp = r_ts;
  assign msg_count       = r_msg;
  assign err_count       = r_err;
  assign skip_count      = r_skip;

endmodule

// File: tb/tb_itch_event_parser.sv
// Bench for itch_event_parser: a 64-bit and a 128-bit instance share clock and
// reset; expected events are queued at send time and popped when emitted.
module tb_itch_event_parser;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [63:0]  a_tdata;  logic [7:0]  a_tkeep;
  logic a_tvalid, a_tlast, a_tready, a_evt_valid, a_evt_ready, a_side;
  logic [7:0] a_type; logic [63:0] a_ref, a_stock; logic [31:0] a_shares, a_price;
  logic [47:0] a_ts; logic [31:0] a_msg, a_err, a_skip;

  logic [127:0] b_tdata;  logic [15:0] b_tkeep;
  logic b_tvalid, b_tlast, b_tready, b_evt_valid, b_evt_ready, b_side;
  logic [7:0] b_type; logic [63:0] b_ref, b_stock; logic [31:0] b_shares, b_price;
  logic [47:0] b_ts; logic [31:0] b_msg, b_err, b_skip;

  itch_event_parser #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
    .s_axis_tlast(a_tlast), .s_axis_tready(a_tready),
    .m_evt_valid(a_evt_valid), .m_evt_ready(a_evt_ready), .m_evt_type(a_type),
    .m_evt_order_ref(a_ref), .m_evt_side(a_side), .m_evt_shares(a_shares),
    .m_evt_stock(a_stock), .m_evt_price(a_price), .m_evt_timestamp(a_ts),
    .msg_count(a_msg), .err_count(a_err), .skip_count(a_skip));

  itch_event_parser #(.DATA_WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
    .m_evt_valid(b_evt_valid), .m_evt_ready(b_evt_ready), .m_evt_type(b_type),
    .m_evt_order_ref(b_ref), .m_evt_side(b_side), .m_evt_shares(b_shares),
    .m_evt_stock(b_stock), .m_evt_price(b_price), .m_evt_timestamp(b_ts),
    .msg_count(b_msg), .err_count(b_err), .skip_count(b_skip));

  typedef struct packed {
    logic [7:0]  typ;
    logic [63:0] oref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
    logic [47:0] ts;
  } evt_t;

  evt_t exp_a[$], exp_b[$];
  int errors = 0, checks = 0;
  logic [7:0] msg [0:63];
  int msg_len;

  function automatic evt_t exp_of(evt_t e);
    evt_t r = e;
    if (e.typ != 8'h41 && e.typ != 8'h46) begin r.side = 1'b0; r.stock = '0; r.price = '0; end
    if (e.typ == 8'h44) r.shares = '0;
    return r;
  endfunction

  task automatic put_be(input int off, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) msg[off+i] = v[8*(n-1-i) +: 8];
  endtask

  // Encode wire bytes from the field values; fields a type does not carry are not written.
  task automatic build(input evt_t e);
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = e.typ;
    put_be(1, 64'h0001_0002, 4);
    put_be(5, {16'h0, e.ts}, 6);
    put_be(11, e.oref, 8);
    case (e.typ)
      8'h41, 8'h46: begin
        msg[19] = e.side ? 8'h53 : 8'h42;
        put_be(20, {32'h0, e.shares}, 4);
        put_be(24, e.stock, 8);
        put_be(32, {32'h0, e.price}, 4);
        if (e.typ == 8'h46) begin put_be(36, 64'h4D50_4944, 4); msg_len = 40; end
        else msg_len = 36;
      end
      8'h45: begin put_be(19, {32'h0, e.shares}, 4); put_be(23, 64'h99, 8); msg_len = 31; end
      8'h58: begin put_be(19, {32'h0, e.shares}, 4); msg_len = 23; end
      default: msg_len = 19;
    endcase
  endtask

  task automatic send(input bit wide, input int len, input int badkeep_beat,
                      input int abort_beat, output bit ok);
    int kw = wide ? 16 : 8;
    int nb = (len + kw - 1) / kw;
    ok = 1'b0;
    for (int b = 0; b < nb; b++) begin
      logic [127:0] d = '0;
      logic [15:0]  k = '0;
      int t = 0;
      @(negedge clk);
      for (int l = 0; l < kw; l++)
        if (b*kw + l < len) begin d[8*l +: 8] = msg[b*kw + l]; k[l] = 1'b1; end
      if (b == badkeep_beat) k[kw-1] = 1'b0;
      if (wide) begin b_tdata = d; b_tkeep = k; b_tvalid = 1'b1; b_tlast = (b == nb-1); end
      else begin a_tdata = d[63:0]; a_tkeep = k[7:0]; a_tvalid = 1'b1; a_tlast = (b == nb-1); end
      if (b == abort_beat) begin
        #2 rst_n = 1'b0;
        a_tvalid = 1'b0; b_tvalid = 1'b0; a_tlast = 1'b0; b_tlast = 1'b0;
        ok = 1'b1;
        return;
      end
      while (!(wide ? b_tready : a_tready)) begin
        @(negedge clk);
        t++;
        if (t > 200) begin
          checks++; errors++;
          $display("FAIL send_tready_timeout: tready stayed 0, required 1 within 200 cycles");
          a_tvalid = 1'b0; b_tvalid = 1'b0;
          return;
        end
      end
      @(posedge clk);
    end
    #1;
    if (wide) begin b_tvalid = 1'b0; b_tlast = 1'b0; end
    else begin a_tvalid = 1'b0; a_tlast = 1'b0; end
    ok = 1'b1;
  endtask

  task automatic wait_evt(input bit wide, input int budget, output evt_t obs,
                          output int cyc, output bit got);
    got = 1'b0; cyc = 0; obs = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (wide ? b_evt_valid : a_evt_valid) begin
        obs = wide ? {b_type, b_ref, b_side, b_shares, b_stock, b_price, b_ts}
                   : {a_type, a_ref, a_side, a_shares, a_stock, a_price, a_ts};
        cyc = i; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_tvalid = 0; a_tlast = 0; a_tdata = '0; a_tkeep = '0; a_evt_ready = 1'b1;
    b_tvalid = 0; b_tlast = 0; b_tdata = '0; b_tkeep = '0; b_evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_tready, a_evt_valid, a_type, a_ref, a_side, a_shares, a_stock, a_price, a_ts,
         a_msg, a_err, a_skip} !== '0) begin
      errors++; $display("FAIL reset_outputs_64: some output nonzero (tready=%b valid=%b msg=%0d), required all 0",
                         a_tready, a_evt_valid, a_msg);
    end
    checks++;
    if ({b_tready, b_evt_valid, b_msg, b_err, b_skip} !== '0) begin
      errors++; $display("FAIL reset_outputs_128: tready=%b valid=%b, required 0", b_tready, b_evt_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_tready, b_tready} !== 2'b11) begin
      errors++; $display("FAIL reset_release_tready: got %b, required 11", {a_tready, b_tready});
    end
  endtask

  task automatic check_event(input bit wide, input string name);
    evt_t obs, ex; int cyc; bit got;
    wait_evt(wide, 20, obs, cyc, got);
    checks++;
    if (!got || cyc !== 2) begin
      errors++; $display("FAIL %s_latency: valid seen=%0d after %0d cycles, required 1 after 2", name, got, cyc);
    end
    ex = wide ? exp_b.pop_front() : exp_a.pop_front();
    checks++;
    if (obs !== ex) begin
      errors++; $display("FAIL %s_record: got %h, required %h", name, obs, ex);
    end
  endtask

  task automatic expect_drop(input string name);
    evt_t obs; int cyc; bit got;
    wait_evt(1'b0, 6, obs, cyc, got);
    checks++;
    if (got !== 1'b0) begin
      errors++; $display("FAIL %s_no_event: valid=%b, required 0", name, got);
    end
  endtask

  task automatic test_add_order_64;
    evt_t e; bit ok;
    e = '{typ:8'h41, oref:64'h1234, side:1'b0, shares:32'd100, stock:64'h4141504C20202020,
          price:32'd1502500, ts:48'h0000_1234_5678};
    build(e); exp_a.push_back(exp_of(e));
    send(1'b0, msg_len, -1, -1, ok);
    check_event(1'b0, "add64");
    @(negedge clk);
    checks++;
    if (a_msg !== 32'd1 || a_evt_valid !== 1'b0) begin
      errors++; $display("FAIL add64_msg_count: msg=%0d valid=%b, required 1 and 0", a_msg, a_evt_valid);
    end
  endtask

  task automatic test_back_to_back;
    evt_t e, ee, obs; int cyc; bit got, ok1;
    b_evt_ready = 1'b0;
    e = '{typ:8'h45, oref:64'd7, side:1'b1, shares:32'd50, stock:64'hDEAD, price:32'd77, ts:48'h0A0B0C0D0E0F};
    build(e); exp_b.push_back(exp_of(e));
    send(1'b1, msg_len, -1, -1, ok1);
    wait_evt(1'b1, 20, obs, cyc, got);
    ee = exp_b.pop_front();
    checks++;
    if (!got || cyc !== 2 || obs !== ee) begin
      errors++; $display("FAIL exec_event: seen=%0d cyc=%0d got %h, required 1 2 %h", got, cyc, obs, ee);
    end
    e = '{typ:8'h44, oref:64'd7, side:1'b0, shares:32'd999, stock:64'h0, price:32'd0, ts:48'h0A0B0C0D1000};
    build(e); exp_b.push_back(exp_of(e));
    fork
      begin
        bit ok2;
        send(1'b1, msg_len, -1, -1, ok2);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          checks++;
          if (b_evt_valid !== 1'b1 || b_tready !== 1'b0 ||
              {b_type, b_ref, b_side, b_shares, b_stock, b_price, b_ts} !== ee) begin
            errors++; $display("FAIL hold_stable_%0d: valid=%b tready=%b rec=%h, required 1 0 %h",
                               i, b_evt_valid, b_tready,
                               {b_type, b_ref, b_side, b_shares, b_stock, b_price, b_ts}, ee);
          end
        end
        b_evt_ready = 1'b1;
      end
    join
    check_event(1'b1, "delete128");
    @(negedge clk);
    checks++;
    if (b_msg !== 32'd2) begin
      errors++; $display("FAIL b2b_msg_count: got %0d, required 2", b_msg);
    end
  endtask

  task automatic test_length_errors;
    evt_t e; bit ok;
    e = '{typ:8'h58, oref:64'd5, side:1'b0, shares:32'd10, stock:64'h0, price:32'd0, ts:48'h1};
    build(e); msg_len = 22;
    send(1'b0, msg_len, -1, -1, ok);
    expect_drop("x_short");
    checks++;
    if (a_err !== 32'd1) begin errors++; $display("FAIL x_short_err_count: got %0d, required 1", a_err); end
    e = '{typ:8'h46, oref:64'd6, side:1'b1, shares:32'd20, stock:64'h4D53465420202020, price:32'd300, ts:48'h2};
    build(e); msg_len = 50;
    send(1'b0, msg_len, -1, -1, ok);
    expect_drop("f_long");
    checks++;
    if (a_err !== 32'd2) begin errors++; $display("FAIL f_long_err_count: got %0d, required 2", a_err); end
  endtask

  task automatic test_bad_keep;
    evt_t e; bit ok;
    e = '{typ:8'h41, oref:64'h55, side:1'b1, shares:32'd1, stock:64'h49424D2020202020, price:32'd9, ts:48'h3};
    build(e);
    send(1'b0, msg_len, 1, -1, ok);
    expect_drop("bad_keep");
    checks++;
    if (a_err !== 32'd3) begin errors++; $display("FAIL bad_keep_err_count: got %0d, required 3", a_err); end
    e = '{typ:8'h41, oref:64'hFEDC_BA98_7654_3210, side:1'b1, shares:32'hDEADBEEF,
          stock:64'h4D53465420202020, price:32'h0102_0304, ts:48'hFFFF_0000_1111};
    build(e); exp_a.push_back(exp_of(e));
    send(1'b0, msg_len, -1, -1, ok);
    check_event(1'b0, "after_bad_keep");
    @(negedge clk);
    checks++;
    if (a_msg !== 32'd2) begin errors++; $display("FAIL after_bad_keep_msg_count: got %0d, required 2", a_msg); end
  endtask

  task automatic test_unsupported;
    bit ok;
    for (int i = 0; i < 64; i++) msg[i] = 8'h00;
    msg[0] = 8'h53; msg_len = 12;
    send(1'b0, msg_len, -1, -1, ok);
    expect_drop("unsupported");
    checks++;
    if (a_skip !== 32'd1 || a_err !== 32'd3) begin
      errors++; $display("FAIL unsupported_counts: skip=%0d err=%0d, required 1 3", a_skip, a_err);
    end
  endtask

  task automatic test_reset_mid;
    evt_t e; bit ok;
    e = '{typ:8'h41, oref:64'h77, side:1'b0, shares:32'd5, stock:64'h5453534C20202020, price:32'd11, ts:48'h4};
    build(e);
    send(1'b0, msg_len, -1, 3, ok);
    #1;
    checks++;
    if ({a_tready, a_evt_valid, a_type, a_ref, a_side, a_shares, a_stock, a_price, a_ts,
         a_msg, a_err, a_skip} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: tready=%b msg=%0d err=%0d skip=%0d, required all 0",
                         a_tready, a_msg, a_err, a_skip);
    end
    checks++;
    if ({b_evt_valid, b_msg} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs_128: msg=%0d, required 0", b_msg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = '{typ:8'h41, oref:64'h0000_0000_0000_1234, side:1'b1, shares:32'd300, stock:64'h474F4F4720202020,
          price:32'd2800000, ts:48'h0000_0000_ABCD};
    build(e); exp_a.push_back(exp_of(e));
    send(1'b0, msg_len, -1, -1, ok);
    check_event(1'b0, "post_reset_add");
    @(negedge clk);
    checks++;
    if (a_msg !== 32'd1 || a_err !== 32'd0) begin
      errors++; $display("FAIL post_reset_counts: msg=%0d err=%0d, required 1 0", a_msg, a_err);
    end
  endtask

  initial begin
    test_reset;
    test_add_order_64;
    test_back_to_back;
    test_length_errors;
    test_bad_keep;
    test_unsupported;
    test_reset_mid;
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d/%0d left, required 0/0", exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/itch_event_parser.md
# itch_event_parser

Parametrised ITCH 5.0 message parser, the successor to the Add-Order-only parser. It accepts one ITCH message per AXI-Stream packet at a configurable bus width. It decodes Add Order ('A'), Add Order MPID ('F'), Order Executed ('E'), Order Cancel ('X') and Order Delete ('D') into a single event record with valid/ready backpressure. It sits between the MAC/UDP de-framer and the order book / MoE feature extractor.

## Interface
Parameters:
- DATA_WIDTH, 64: AXI-Stream data width in bits; legal values are 64 and 128.
- MAX_MSG_BYTES, 48: byte capture buffer depth; must be ≥ 40.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  message bytes; stream byte k of a beat is in tdata[8k+7:8k].
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tlast  in  1  last beat of the message.
- s_axis_tready  out  1  parser accepts the beat.
- m_evt_valid  out  1  event record valid.
- m_evt_ready  in  1  downstream accepts the event.
- m_evt_type  out  8  ITCH type byte (0x41/0x46/0x45/0x58/0x44).
- m_evt_order_ref  out  64  order reference number.
- m_evt_side  out  1  0 = 'B', 1 = 'S'; 0 for E/X/D.
- m_evt_shares  out  32  shares for A/F; executed shares for E; cancelled shares for X; 0 for D.
- m_evt_stock  out  64  ticker for A/F; 0 otherwise.
- m_evt_price  out  32  price for A/F; 0 otherwise.
- m_evt_timestamp  out  48  nanoseconds since midnight.
- msg_count  out  CNT_WIDTH  number of events emitted; wraps.
- err_count  out  CNT_WIDTH  number of malformed packets dropped; saturates.
- skip_count  out  CNT_WIDTH  number of unsupported-type packets dropped; saturates.

## Operation
- **Byte layout.** Message byte 0 is the type byte. All fields are big-endian.
- **Common field offsets.** Timestamp is bytes 5–10. Order ref is bytes 11–18.
- **A/F offsets.** Side is byte 19 (0x53 → 1). Shares are bytes 20–23. Stock is bytes 24–31. Price is bytes 32–35.
- **E/X offsets.** Shares are bytes 19–22.
- **Required lengths.** A = 36, F = 40, E = 31, X = 23, D = 19.
- **COLLECT state (reset state).**
  - s_axis_tready = 1.
  - On each accepted beat, enabled bytes are written at byte_cnt and byte_cnt advances by popcount(tkeep).
  - Bytes beyond MAX_MSG_BYTES are discarded and set the overflow flag.
  - The bad-keep flag is set by either condition:
    - a non-last beat without all-ones tkeep;
    - a last beat whose tkeep is not contiguous from bit 0, or is zero.
  - On the tlast beat, go to CHECK.
- **CHECK state (1 cycle).**
  - s_axis_tready = 0.
  - Type not in {A, F, E, X, D}: skip_count++, go to COLLECT.
  - Else, if overflow, bad-keep, or total bytes ≠ required length: err_count++, go to COLLECT.
  - Else, load the output registers from the buffer, set m_evt_valid = 1, and go to EMIT.
- **EMIT state.**
  - s_axis_tready = 0.
  - Outputs are held stable.
  - On m_evt_valid && m_evt_ready: m_evt_valid = 0, msg_count++, clear byte_cnt and flags, go to COLLECT.
- **Counters.** err_count and skip_count saturate at all-ones. msg_count wraps.
- **Reset.** An asynchronous assert at any point, including mid-packet or in EMIT, does the following:
  - All outputs go to 0, except s_axis_tready, which goes to 1 after deassertion.
  - State goes to COLLECT. byte_cnt, flags and counters clear.
  - A partially received packet is lost. The bench must restart on a packet boundary.

## Timing
- s_axis_tready reset value is 0 while rst_n is low, then 1 from the first cycle after deassertion.
- Latency: tlast accepted at cycle N → m_evt_valid high at N+2 (CHECK at N+1).
- Throughput: one message per (beats + 2) cycles when m_evt_ready is held high.
- Example: an A message at 64-bit width is 5 beats + 2 = 7 cycles.
- s_axis_tready is low exactly during CHECK and EMIT. The bench must not assume it is combinationally dependent on m_evt_ready.
- m_evt_* fields change only on the CHECK→EMIT transition.
- With DATA_WIDTH = 128, an A message is 3 beats; the last beat has tkeep = 16'h000F.

## Test plan
- **A message, 64-bit.** order_ref 0x0000_0000_0000_1234, 'B', 100 shares, "AAPL    ", price 1502500, ts 0x0000_1234_5678, m_evt_ready = 1 → one event with those values; type 0x41; m_evt_valid at tlast + 2; msg_count = 1.
- **Back-to-back E then D, 128-bit.**
  - E: ref 7, 50 shares.
  - D: ref 7.
  - m_evt_ready held low 10 cycles.
  - Required: E is held stable with tready = 0 throughout; after ready rises, D follows with shares = 0; msg_count = 2.
- **Length errors.**
  - X message truncated to 22 bytes → err_count = 1, no event.
  - F message padded to 50 bytes → overflow, err_count = 2.
- **Bad tkeep.** Non-last beat with tkeep = 8'h7F → err_count++, and the next valid A parses correctly.
- **Unsupported type.** Type 'S' (0x53), 12 bytes → skip_count = 1, no event, no err_count change.
- **Reset mid-operation.**
  - rst_n pulsed low during beat 3 of an A message → all outputs 0, counters 0.
  - A fresh A message afterwards parses with the expected latency.
